// File: rtl/out_uart_pkg.sv
// Shared types and frame constants for the OUT-instruction UART transmitter.
package out_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int WORD_BYTES = 2;
    // Start and stop bits frame the payload.
    localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/out_uart_tx_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    // When full, the slot under wr_ptr is the one being read out this cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/out_uart_tx.sv
// Queues 16-bit OUT words and sends each as two 8N1 bytes, high byte first.
module out_uart_tx
    import out_uart_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [15:0]            wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   overflow,
    output logic                   txd
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic          LAST_BYTE = 1'(WORD_BYTES - 1);

    // Handshake: wr_en is a one-cycle strobe with no ready. A push is taken
    // when full is low or a pop happens the same cycle; otherwise the word is
    // dropped and overflow latches until rst.

    tx_state_t     state, state_next;
    logic [CW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_cnt, bit_next;
    logic          byte_sel, byte_sel_next;
    logic [7:0]    shift, shift_next;
    logic [15:0]   hold, hold_next;
    logic          txd_next;
    logic          pop;
    logic          fifo_empty;
    logic [15:0]   fifo_rd;
    logic          bit_done;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (fifo_rd),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign busy     = (state != IDLE);
    assign bit_done = (baud_cnt == '0);

    always_comb begin
        state_next    = state;
        baud_next     = baud_cnt;
        bit_next      = bit_cnt;
        byte_sel_next = byte_sel;
        shift_next    = shift;
        hold_next     = hold;
        txd_next      = 1'b1;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    hold_next     = fifo_rd;
                    shift_next    = fifo_rd[15:8];
                    byte_sel_next = 1'b0;
                    baud_next     = BAUD_MAX;
                    state_next    = START;
                end
            end
            START: begin
                txd_next = 1'b0;
                if (bit_done) begin
                    baud_next  = BAUD_MAX;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt - CW'(1);
                end
            end
            DATA: begin
                txd_next = shift[0];
                if (bit_done) begin
                    baud_next = BAUD_MAX;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_cnt + 3'd1;
                        shift_next = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_next = baud_cnt - CW'(1);
                end
            end
            STOP: begin
                txd_next = 1'b1;
                if (bit_done) begin
                    baud_next = BAUD_MAX;
                    if (byte_sel == LAST_BYTE) begin
                        state_next = IDLE;
                    end else begin
                        // Low byte follows immediately with no idle gap.
                        shift_next    = hold[7:0];
                        byte_sel_next = 1'b1;
                        state_next    = START;
                    end
                end else begin
                    baud_next = baud_cnt - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_sel <= 1'b0;
            shift    <= '0;
            hold     <= '0;
            txd      <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            byte_sel <= byte_sel_next;
            shift    <= shift_next;
            hold     <= hold_next;
            // Registered line: txd follows the state one cycle later.
            txd      <= txd_next;
            if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
